// File: rtl/seg_sym_drv.sv
// seg_sym_drv: bar-level driver for one game lane.
// Launches a note on note_start and advances a 3-bit bar level once every
// STEP_TICKS beat ticks. It grades the player's hit against the current level,
// or flags a miss on timeout, and holds the judged bar for SHOW_TICKS ticks
// before returning to idle.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick         one-cycle beat-subdivision enable
//   note_start   one-cycle launch pulse
//   hit          one-cycle debounced button pulse
//   state        bar level 0..7 to the segment symbol mapper
//   active       high while the note is in flight
//   judge        00 none, 01 miss, 10 good, 11 perfect (held until next launch)
//   judge_valid  one-cycle pulse when judge is updated
//   overrun      one-cycle pulse when a launch is dropped outside idle
module seg_sym_drv #(
  parameter int STEP_TICKS = 4,
  parameter int SHOW_TICKS = 8,
  parameter int GOOD_MIN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       note_start,
  input  logic       hit,
  output logic [2:0] state,
  output logic       active,
  output logic [1:0] judge,
  output logic       judge_valid,
  output logic       overrun
);

  localparam int PW = $clog2(STEP_TICKS + 1);
  localparam int SW = $clog2(SHOW_TICKS + 1);

  localparam logic [1:0] J_NONE    = 2'b00;
  localparam logic [1:0] J_MISS    = 2'b01;
  localparam logic [1:0] J_GOOD    = 2'b10;
  localparam logic [1:0] J_PERFECT = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, SHOW} fsm_t;

  fsm_t          fsm;
  logic [PW-1:0] presc;
  logic [SW-1:0] show_cnt;

  // Full bar is perfect; GOOD_MIN..6 is good; anything lower is an early miss.
  function automatic logic [1:0] grade(input logic [2:0] lvl);
    if (lvl == 3'd7)               return J_PERFECT;
    else if (lvl >= 3'(GOOD_MIN))  return J_GOOD;
    else                           return J_MISS;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      state       <= 3'd0;
      active      <= 1'b0;
      judge       <= J_NONE;
      judge_valid <= 1'b0;
      overrun     <= 1'b0;
      presc       <= '0;
      show_cnt    <= '0;
    end else begin
      judge_valid <= 1'b0;
      overrun     <= 1'b0;
      case (fsm)
        IDLE: begin
          state  <= 3'd0;
          active <= 1'b0;
          if (note_start) begin
            fsm    <= RUN;
            state  <= 3'd1;
            active <= 1'b1;
            presc  <= '0;
            judge  <= J_NONE;
          end
        end
        RUN: begin
          if (note_start) overrun <= 1'b1;
          // A hit takes priority over a coincident step boundary, so it is
          // graded on the level the player actually saw.
          if (hit) begin
            judge       <= grade(state);
            judge_valid <= 1'b1;
            active      <= 1'b0;
            show_cnt    <= '0;
            fsm         <= SHOW;
          end else if (tick) begin
            if (presc == PW'(STEP_TICKS - 1)) begin
              presc <= '0;
              if (state != 3'd7) begin
                state <= state + 3'd1;
              end else begin
                judge       <= J_MISS;
                judge_valid <= 1'b1;
                active      <= 1'b0;
                show_cnt    <= '0;
                fsm         <= SHOW;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        SHOW: begin
          active <= 1'b0;
          if (note_start) overrun <= 1'b1;
          if (tick) begin
            if (show_cnt == SW'(SHOW_TICKS - 1)) begin
              show_cnt <= '0;
              state    <= 3'd0;
              fsm      <= IDLE;
            end else begin
              show_cnt <= show_cnt + SW'(1);
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_sym_drv.sv
module tb_seg_sym_drv;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, note_start, hit;
  logic [2:0] state,  state1;
  logic       active, active1;
  logic [1:0] judge,  judge1;
  logic       jv,     jv1;
  logic       ovr,    ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_sym_drv dut (
    .clk(clk), .rst(rst), .tick(tick), .note_start(note_start), .hit(hit),
    .state(state), .active(active), .judge(judge), .judge_valid(jv), .overrun(ovr)
  );

  seg_sym_drv #(.STEP_TICKS(1), .SHOW_TICKS(8), .GOOD_MIN(5)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .note_start(note_start), .hit(hit),
    .state(state1), .active(active1), .judge(judge1), .judge_valid(jv1), .overrun(ovr1)
  );

  // One clock with the given inputs held across the edge; outputs are
  // sampled 1 time unit after that edge.
  task automatic step(input logic t, input logic ns, input logic h);
    tick = t; note_start = ns; hit = h;
    @(posedge clk); #1;
    tick = 1'b0; note_start = 1'b0; hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    step(0, 1, 0);
    ticks(12);
    n_checks++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL rst_pre_state: got %0d want 4", state); end
    rst = 1'b1;
    step(1, 0, 1);
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %0b want 0", active); end
    n_checks++;
    if (judge !== 2'b00) begin n_fail++; $display("FAIL rst_judge: got %0d want 0", judge); end
    n_checks++;
    if (jv !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got jv=%0b ovr=%0b want 0 0", jv, ovr); end
    step(0, 1, 0);
    rst = 1'b0;
    step(0, 0, 0);
    n_checks++;
    if (state !== 3'd0 || active !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got state=%0d active=%0b want 0 0", state, active); end
  endtask

  task automatic test_timeout;
    int exp_s;
    do_reset();
    step(0, 1, 0);
    n_checks++;
    if (state !== 3'd1 || active !== 1'b1 || judge !== 2'b00)
      begin n_fail++; $display("FAIL to_launch: got state=%0d active=%0b judge=%0d want 1 1 0", state, active, judge); end
    for (int k = 1; k <= 27; k++) begin
      step(1, 0, 0);
      exp_s = (k >= 24) ? 7 : 1 + k / 4;
      n_checks++;
      if (state !== 3'(exp_s) || jv !== 1'b0)
        begin n_fail++; $display("FAIL to_tick%0d: got state=%0d jv=%0b want %0d 0", k, state, jv, exp_s); end
    end
    step(1, 0, 0);
    n_checks++;
    if (judge !== 2'b01 || jv !== 1'b1 || active !== 1'b0 || state !== 3'd7)
      begin n_fail++; $display("FAIL to_judge: got judge=%0d jv=%0b active=%0b state=%0d want 1 1 0 7", judge, jv, active, state); end
    step(0, 0, 0);
    n_checks++;
    if (jv !== 1'b0) begin n_fail++; $display("FAIL to_jv_once: got %0b want 0", jv); end
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 0);
      exp_s = (k == 8) ? 0 : 7;
      n_checks++;
      if (state !== 3'(exp_s) || jv !== 1'b0)
        begin n_fail++; $display("FAIL to_show%0d: got state=%0d jv=%0b want %0d 0", k, state, jv, exp_s); end
    end
    n_checks++;
    if (judge !== 2'b01) begin n_fail++; $display("FAIL to_judge_hold: got %0d want 1", judge); end
  endtask

  task automatic test_perfect;
    do_reset();
    step(0, 1, 0);
    ticks(24);
    n_checks++;
    if (state !== 3'd7) begin n_fail++; $display("FAIL pf_full: got %0d want 7", state); end
    step(0, 0, 1);
    n_checks++;
    if (judge !== 2'b11 || jv !== 1'b1 || active !== 1'b0)
      begin n_fail++; $display("FAIL pf_judge: got judge=%0d jv=%0b active=%0b want 3 1 0", judge, jv, active); end
    step(0, 0, 1);
    n_checks++;
    if (judge !== 2'b11 || jv !== 1'b0)
      begin n_fail++; $display("FAIL pf_show_hit: got judge=%0d jv=%0b want 3 0", judge, jv); end
    ticks(7);
    n_checks++;
    if (state !== 3'd7) begin n_fail++; $display("FAIL pf_hold: got %0d want 7", state); end
    ticks(1);
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL pf_idle: got %0d want 0", state); end
  endtask

  task automatic test_good_coincident;
    do_reset();
    step(0, 1, 0);
    ticks(19);
    n_checks++;
    if (state !== 3'd5) begin n_fail++; $display("FAIL gd_pre: got %0d want 5", state); end
    step(1, 0, 1);
    n_checks++;
    if (judge !== 2'b10 || jv !== 1'b1 || state !== 3'd5)
      begin n_fail++; $display("FAIL gd_judge: got judge=%0d jv=%0b state=%0d want 2 1 5", judge, jv, state); end
    ticks(4);
    n_checks++;
    if (state !== 3'd5 || active !== 1'b0) begin n_fail++; $display("FAIL gd_frozen: got state=%0d active=%0b want 5 0", state, active); end
  endtask

  task automatic test_miss_overrun;
    do_reset();
    step(0, 1, 0);
    step(0, 1, 0);
    n_checks++;
    if (ovr !== 1'b1 || state !== 3'd1) begin n_fail++; $display("FAIL ov_run: got ovr=%0b state=%0d want 1 1", ovr, state); end
    ticks(8);
    n_checks++;
    if (state !== 3'd3 || ovr !== 1'b0) begin n_fail++; $display("FAIL ms_pre: got state=%0d ovr=%0b want 3 0", state, ovr); end
    step(0, 0, 1);
    n_checks++;
    if (judge !== 2'b01 || jv !== 1'b1) begin n_fail++; $display("FAIL ms_judge: got judge=%0d jv=%0b want 1 1", judge, jv); end
    step(0, 1, 0);
    n_checks++;
    if (ovr !== 1'b1 || state !== 3'd3 || active !== 1'b0)
      begin n_fail++; $display("FAIL ov_show: got ovr=%0b state=%0d active=%0b want 1 3 0", ovr, state, active); end
    step(0, 0, 0);
    n_checks++;
    if (ovr !== 1'b0 || jv !== 1'b0) begin n_fail++; $display("FAIL ov_once: got ovr=%0b jv=%0b want 0 0", ovr, jv); end
    ticks(8);
    n_checks++;
    if (state !== 3'd0 || judge !== 2'b01) begin n_fail++; $display("FAIL ms_idle: got state=%0d judge=%0d want 0 1", state, judge); end
    step(0, 1, 0);
    n_checks++;
    if (state !== 3'd1 || judge !== 2'b00 || active !== 1'b1 || ovr !== 1'b0)
      begin n_fail++; $display("FAIL ms_relaunch: got state=%0d judge=%0d active=%0b ovr=%0b want 1 0 1 0", state, judge, active, ovr); end
  endtask

  task automatic test_idle_and_fast;
    do_reset();
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    n_checks++;
    if (state !== 3'd0 || active !== 1'b0 || judge !== 2'b00 || jv !== 1'b0 || ovr !== 1'b0)
      begin n_fail++; $display("FAIL idle_quiet: got state=%0d active=%0b judge=%0d jv=%0b ovr=%0b want 0 0 0 0 0", state, active, judge, jv, ovr); end
    step(0, 1, 0);
    n_checks++;
    if (state1 !== 3'd1) begin n_fail++; $display("FAIL st1_launch: got %0d want 1", state1); end
    for (int k = 1; k <= 6; k++) begin
      step(1, 0, 0);
      n_checks++;
      if (state1 !== 3'(1 + k) || jv1 !== 1'b0)
        begin n_fail++; $display("FAIL st1_tick%0d: got state=%0d jv=%0b want %0d 0", k, state1, jv1, 1 + k); end
    end
    step(1, 0, 0);
    n_checks++;
    if (judge1 !== 2'b01 || jv1 !== 1'b1 || state1 !== 3'd7)
      begin n_fail++; $display("FAIL st1_timeout: got judge=%0d jv=%0b state=%0d want 1 1 7", judge1, jv1, state1); end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; note_start = 1'b0; hit = 1'b0;
    #2;
    test_reset();
    test_timeout();
    test_perfect();
    test_good_coincident();
    test_miss_overrun();
    test_idle_and_fast();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
